ddmtd_loop_dco: RTL and testbench

Closed-loop consumer of the DDMTD phase-error stream. Takes `phase_valid`/`phase_err_beat` samples and runs them through a PI loop filter. The filter steers a phase-accumulator NCO whose MSB is the regenerated feedback clock, which is fed back to the sampler's `clk_fb_in`. It also reports lock and frequency-clamp status.

---
 rtl/ddmtd_loop_dco.sv | 152 +++++++++++++++
 tb/tb_ddmtd_loop_dco.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddmtd_loop_dco.sv
`default_nettype none
// -----------------------------------------------------------------------------
// ddmtd_loop_dco : PI loop filter on DDMTD phase error steering a phase-acc NCO
// Rev 1.0
// -----------------------------------------------------------------------------
module ddmtd_loop_dco #(
  parameter int               COUNT_W  = 16,
  parameter int               ACC_W    = 24,
  parameter logic [ACC_W-1:0] FTW_NOM  = 24'h100000,
  parameter logic [ACC_W-1:0] FTW_MIN  = 24'h080000,
  parameter logic [ACC_W-1:0] FTW_MAX  = 24'h200000,
  parameter int               KP_SHIFT = 4,
  parameter int               KI_SHIFT = 8,
  parameter int               LOCK_TOL = 2,
  parameter int               LOCK_CNT = 8
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               phase_valid,
  input  logic [COUNT_W-1:0] phase_err_beat,
  output logic               clk_fb_out,
  output logic [ACC_W-1:0]   ftw,
  output logic               locked,
  output logic               clamp
);

  localparam int IW = ACC_W + KI_SHIFT;
  localparam int RW = IW + 2;
  localparam int CW = $clog2(LOCK_CNT + 1);

  // Integrator saturates symmetrically, so the most negative code is never used.
  localparam logic signed [IW:0]     SAT_HI  = (IW+1)'((64'sd1 <<< (IW - 1)) - 64'sd1);
  localparam logic signed [IW:0]     SAT_LO  = -SAT_HI;
  localparam logic signed [RW-1:0]   NOM_X   = {{(RW-ACC_W){1'b0}}, FTW_NOM};
  localparam logic signed [RW-1:0]   MIN_X   = {{(RW-ACC_W){1'b0}}, FTW_MIN};
  localparam logic signed [RW-1:0]   MAX_X   = {{(RW-ACC_W){1'b0}}, FTW_MAX};
  localparam logic [CW-1:0]          CNT_MAX = CW'(LOCK_CNT);
  localparam logic [COUNT_W:0]       TOL     = (COUNT_W+1)'(LOCK_TOL);

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    clk_fb_out_q, clk_fb_out_d;
  logic signed [IW-1:0]    integ_q, integ_d;
  logic signed [ACC_W-1:0] err_q, err_d;
  logic                    upd_q, upd_d;
  logic [ACC_W-1:0]        ftw_q, ftw_d;
  logic [CW-1:0]           lock_cnt_q, lock_cnt_d;
  logic                    locked_q, locked_d;
  logic                    clamp_q, clamp_d;

  logic signed [IW:0]      integ_sum;
  logic signed [RW-1:0]    err_x, integ_x, prop, ipart, raw;
  logic [COUNT_W:0]        err_ext, err_abs;
  logic                    in_tol;
  logic [CW-1:0]           cnt_inc;

  always_comb begin
    integ_sum = {integ_q[IW-1], integ_q}
              + {{(IW+1-COUNT_W){phase_err_beat[COUNT_W-1]}}, phase_err_beat};
    err_x     = {{(RW-ACC_W){err_q[ACC_W-1]}}, err_q};
    integ_x   = {{(RW-IW){integ_q[IW-1]}}, integ_q};
    prop      = err_x <<< KP_SHIFT;
    ipart     = integ_x >>> KI_SHIFT;
    raw       = NOM_X + prop + ipart;
    // One extra bit so the most negative error has a representable magnitude.
    err_ext   = {phase_err_beat[COUNT_W-1], phase_err_beat};
    err_abs   = err_ext[COUNT_W] ? (~err_ext + 1'b1) : err_ext;
    in_tol    = (err_abs <= TOL);
    cnt_inc   = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;

    acc_d        = acc_q;
    clk_fb_out_d = clk_fb_out_q;
    integ_d      = integ_q;
    err_d        = err_q;
    upd_d        = upd_q;
    ftw_d        = ftw_q;
    lock_cnt_d   = lock_cnt_q;
    locked_d     = locked_q;
    clamp_d      = clamp_q;

    if (ena) begin
      acc_d        = acc_q + ftw_q;
      clk_fb_out_d = acc_q[ACC_W-1];

      if (upd_q) begin
        upd_d = 1'b0;
        if (raw < MIN_X) begin
          ftw_d   = FTW_MIN;
          clamp_d = 1'b1;
        end else if (raw > MAX_X) begin
          ftw_d   = FTW_MAX;
          clamp_d = 1'b1;
        end else begin
          ftw_d   = raw[ACC_W-1:0];
          clamp_d = 1'b0;
        end
      end

      // A new strobe re-arms stage 2 even if it is consuming the previous sample.
      if (phase_valid) begin
        err_d = {{(ACC_W-COUNT_W){phase_err_beat[COUNT_W-1]}}, phase_err_beat};
        if (integ_sum > SAT_HI) begin
          integ_d = SAT_HI[IW-1:0];
        end else if (integ_sum < SAT_LO) begin
          integ_d = SAT_LO[IW-1:0];
        end else begin
          integ_d = integ_sum[IW-1:0];
        end
        upd_d = 1'b1;

        if (in_tol) begin
          lock_cnt_d = cnt_inc;
          locked_d   = (cnt_inc == CNT_MAX);
        end else begin
          lock_cnt_d = '0;
          locked_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      clk_fb_out_q <= 1'b0;
      integ_q      <= '0;
      err_q        <= '0;
      upd_q        <= 1'b0;
      ftw_q        <= FTW_NOM;
      lock_cnt_q   <= '0;
      locked_q     <= 1'b0;
      clamp_q      <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      clk_fb_out_q <= clk_fb_out_d;
      integ_q      <= integ_d;
      err_q        <= err_d;
      upd_q        <= upd_d;
      ftw_q        <= ftw_d;
      lock_cnt_q   <= lock_cnt_d;
      locked_q     <= locked_d;
      clamp_q      <= clamp_d;
    end
  end

  assign clk_fb_out = clk_fb_out_q;
  assign ftw        = ftw_q;
  assign locked     = locked_q;
  assign clamp      = clamp_q;

endmodule
`default_nettype wire

// File: tb/tb_ddmtd_loop_dco.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_ddmtd_loop_dco : scoreboard bench for the DDMTD loop filter / NCO
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_ddmtd_loop_dco;

  localparam logic [23:0] NOM  = 24'h100000;
  localparam logic [23:0] FMIN = 24'h080000;
  localparam logic [23:0] FMAX = 24'h200000;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        phase_valid = 1'b0;
  logic [15:0] phase_err_beat = '0;
  logic        clk_fb_out;
  logic [23:0] ftw;
  logic        locked;
  logic        clamp;

  int n_tests = 0;
  int n_fail  = 0;

  bit          lock_q[$];
  logic [24:0] ftw_q[$];
  longint      m_integ = 0;
  int          m_cnt = 0;

  ddmtd_loop_dco #(
    .COUNT_W(16), .ACC_W(24), .FTW_NOM(NOM), .FTW_MIN(FMIN), .FTW_MAX(FMAX),
    .KP_SHIFT(4), .KI_SHIFT(8), .LOCK_TOL(2), .LOCK_CNT(8)
  ) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .ena(ena), .phase_valid(phase_valid),
    .phase_err_beat(phase_err_beat), .clk_fb_out(clk_fb_out), .ftw(ftw),
    .locked(locked), .clamp(clamp)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected response of one accepted strobe, queued at issue time.
  task automatic model(input int err);
    longint raw;
    int     a;
    m_integ = m_integ + err;
    if (m_integ > 64'sd2147483647)  m_integ = 64'sd2147483647;
    if (m_integ < -64'sd2147483647) m_integ = -64'sd2147483647;
    a = (err < 0) ? -err : err;
    if (a <= 2) begin
      if (m_cnt < 8) m_cnt++;
    end else begin
      m_cnt = 0;
    end
    lock_q.push_back(m_cnt == 8);
    raw = longint'(NOM) + longint'(err) * 16 + (m_integ >>> 8);
    if (raw < longint'(FMIN))      ftw_q.push_back({1'b1, FMIN});
    else if (raw > longint'(FMAX)) ftw_q.push_back({1'b1, FMAX});
    else                           ftw_q.push_back({1'b0, raw[23:0]});
  endtask

  task automatic send(input int err);
    phase_valid    = 1'b1;
    phase_err_beat = 16'(err);
    if (ena && rst_n) model(err);
    @(negedge clk_sys);
  endtask

  task automatic idle(input int n);
    phase_valid = 1'b0;
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic reset_dut();
    phase_valid = 1'b0;
    rst_n = 1'b0;
    lock_q.delete();
    ftw_q.delete();
    m_integ = 0;
    m_cnt = 0;
    #1;
    check("rst_ftw", ftw, NOM);
    check("rst_clamp", clamp, 0);
    check("rst_locked", locked, 0);
    check("rst_fb", clk_fb_out, 0);
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  function automatic bit fb_exp(input int k);
    return ((k - 1) / 8) % 2 == 1;
  endfunction

  // Monitor: lock result one edge after an accepted strobe, ftw/clamp one edge later.
  initial begin
    bit          p_prev, p_now, p_ftw, el;
    logic [24:0] ef;
    p_prev = 1'b0;
    forever begin
      @(posedge clk_sys);
      p_now  = rst_n && ena && phase_valid;
      p_ftw  = p_prev && rst_n && ena;
      p_prev = p_now;
      #1;
      if (p_now) begin
        if (lock_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL lock_unexpected: got locked=%0b, expected no update", locked);
        end else begin
          el = lock_q.pop_front();
          check("sb_locked", locked, el);
        end
      end
      if (p_ftw) begin
        if (ftw_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL ftw_unexpected: got ftw=0x%0h, expected no update", ftw);
        end else begin
          ef = ftw_q.pop_front();
          check("sb_ftw", ftw, ef[23:0]);
          check("sb_clamp", clamp, ef[24]);
        end
      end
    end
  end

  initial begin
    int pat[8] = '{-2, 0, 2, -2, 0, 2, -2, 0};

    repeat (3) @(negedge clk_sys);
    check("init_ftw", ftw, NOM);
    check("init_clamp", clamp, 0);
    check("init_locked", locked, 0);
    check("init_fb", clk_fb_out, 0);

    // Free run, then freeze with a strobe that must be dropped
    ena = 1'b1;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_sys);
      check("fb_free", clk_fb_out, fb_exp(k));
    end
    check("ftw_free", ftw, NOM);
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      phase_valid    = (i == 10);
      phase_err_beat = 16'd1000;
      @(negedge clk_sys);
      check("fb_frozen", clk_fb_out, 1);
      check("ftw_frozen", ftw, NOM);
    end
    phase_valid = 1'b0;
    ena = 1'b1;
    for (int k = 13; k <= 40; k++) begin
      @(negedge clk_sys);
      check("fb_resume", clk_fb_out, fb_exp(k));
    end
    check("ftw_lost_strobe", ftw, NOM);
    send(0);
    idle(2);
    check("ftw_integ_untouched", ftw, NOM);

    // Single positive error
    reset_dut();
    send(3);
    idle(1);
    check("ftw_plus3", ftw, 24'h100030);
    check("clamp_plus3", clamp, 0);

    // Integral action
    reset_dut();
    repeat (256) send(-1);
    idle(1);
    check("ftw_integ", ftw, 24'h0FFFEF);

    // Clamp high and low
    reset_dut();
    repeat (4200) send(32767);
    idle(1);
    check("ftw_clamp_hi", ftw, FMAX);
    check("clamp_hi", clamp, 1);
    reset_dut();
    repeat (20) send(-32768);
    idle(1);
    check("ftw_clamp_lo", ftw, FMIN);
    check("clamp_lo", clamp, 1);

    // Lock acquisition, loss and re-acquisition
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      send(pat[i]);
      if (i < 7) idle(1);
    end
    check("locked_after_8", locked, 1);
    idle(1);
    send(5);
    check("unlock_big_err", locked, 0);
    idle(1);
    for (int i = 0; i < 7; i++) begin
      send(pat[i]);
      check("locked_held_low", locked, 0);
      idle(1);
    end
    send(1);
    check("relock", locked, 1);
    send(2);
    reset_dut();
    idle(5);
    check("post_rst_ftw", ftw, NOM);
    check("post_rst_clamp", clamp, 0);
    check("post_rst_locked", locked, 0);

    check("queues_drained", lock_q.size() + ftw_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
